// File: rtl/ppg_afe_emulator.sv
// Closed-loop plant model of the PPG photodiode/PGA/ADC chain: LED/DC-comp/gain in, 8-bit samples out.
// Optional build macro AFE_NOISE_EN adds an 8-bit LFSR noise term to each accepted sample.
module ppg_afe_emulator #(
   parameter int unsigned RED_DC_GAIN  = 20,
   parameter int unsigned IR_DC_GAIN   = 22,
   parameter int unsigned RED_AC       = 1,
   parameter int unsigned IR_AC        = 1,
   parameter int unsigned WAVE_MAX     = 15,
   parameter int unsigned COMP_STEP    = 2,
   parameter int unsigned BIAS         = 128,
   parameter int unsigned DARK_RAW     = 16,
   parameter int unsigned SETTLE_TICKS = 2
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       LED_RED,
   input  logic       LED_IR,
   input  logic [3:0] LED_DRIVE,
   input  logic [6:0] DC_Comp,
   input  logic [3:0] PGA_Gain,
   input  logic       CLK_Filter,
   output logic [7:0] ADC,
   output logic       ADC_valid
);

   typedef enum logic [1:0] {CH_NONE, CH_DARK, CH_RED, CH_IR} chan_t;

   chan_t              ch_now, ch_prev;
   logic               filt_q, tick, accept;
   logic [7:0]         wave;
   logic               wave_up;
   logic [7:0]         settle_cnt, settle_eff;
   logic [11:0]        raw;
   logic [13:0]        noise, diff_c;
   logic               s1_valid, s2_valid;
   logic signed [13:0] s1_diff;
   logic [4:0]         s1_gp1;
   logic signed [18:0] s2_prod, sum;
   logic [7:0]         sat;

   assign tick = CLK_Filter & ~filt_q;

   always_comb begin
      if (LED_RED && !LED_IR)      ch_now = CH_RED;
      else if (LED_IR && !LED_RED) ch_now = CH_IR;
      else                         ch_now = CH_DARK;
   end

   // A channel change reloads the settle count and that same tick already consumes one slot
   assign settle_eff = (ch_prev != CH_NONE && ch_now != ch_prev) ? 8'(SETTLE_TICKS) : settle_cnt;
   assign accept     = tick && (settle_eff == 8'd0);

   always_comb begin
      unique case (ch_now)
         CH_RED:  raw = 12'(LED_DRIVE) * 12'(RED_DC_GAIN) + 12'(RED_AC) * 12'(wave);
         CH_IR:   raw = 12'(LED_DRIVE) * 12'(IR_DC_GAIN) + 12'(IR_AC) * 12'(wave);
         default: raw = 12'(DARK_RAW);
      endcase
   end

`ifdef AFE_NOISE_EN
   logic [7:0] lfsr;

   always_ff @(posedge CLK) begin
      if (rst)         lfsr <= 8'hA5;
      else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign noise = 14'(lfsr[1:0]) - 14'd2;
`else
   assign noise = '0;
`endif

   assign diff_c = 14'(raw) - 14'(COMP_STEP) * 14'(DC_Comp) - 14'(BIAS) + noise;

   assign sum = s2_prod + 19'sd128;

   always_comb begin
      if (sum[18])             sat = 8'd0;
      else if (sum > 19'sd255) sat = 8'hFF;
      else                     sat = sum[7:0];
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         filt_q     <= 1'b0;
         wave       <= '0;
         wave_up    <= 1'b1;
         settle_cnt <= '0;
         ch_prev    <= CH_NONE;
         s1_valid   <= 1'b0;
         s1_diff    <= '0;
         s1_gp1     <= '0;
         s2_valid   <= 1'b0;
         s2_prod    <= '0;
         ADC        <= 8'h80;
         ADC_valid  <= 1'b0;
      end else begin
         filt_q   <= CLK_Filter;
         s1_valid <= accept;
         if (tick) begin
            ch_prev    <= ch_now;
            settle_cnt <= (settle_eff != 8'd0) ? settle_eff - 8'd1 : '0;
            if (wave_up) begin
               wave <= wave + 8'd1;
               if (wave == 8'(WAVE_MAX - 1)) wave_up <= 1'b0;
            end else begin
               wave <= wave - 8'd1;
               if (wave == 8'd1) wave_up <= 1'b1;
            end
         end
         if (accept) begin
            s1_diff <= $signed(diff_c);
            s1_gp1  <= 5'(PGA_Gain) + 5'd1;
         end
         s2_valid <= s1_valid;
         if (s1_valid) s2_prod <= $signed({{5{s1_diff[13]}}, s1_diff}) * $signed({14'd0, s1_gp1});
         ADC_valid <= s2_valid;
         if (s2_valid) ADC <= sat;
      end
   end

endmodule

// File: tb/tb_ppg_afe_emulator.sv
// Randomized self-checking bench for ppg_afe_emulator against an arithmetic model of the AFE rules.
module tb_ppg_afe_emulator;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       LED_RED = 1'b0;
   logic       LED_IR = 1'b0;
   logic [3:0] LED_DRIVE = '0;
   logic [6:0] DC_Comp = '0;
   logic [3:0] PGA_Gain = '0;
   logic       CLK_Filter = 1'b0;
   logic [7:0] ADC;
   logic       ADC_valid;

   int checks = 0;
   int errors = 0;

   // model state: prev channel -1 = none yet, 0 dark, 1 red, 2 ir
   int m_wave, m_up, m_prev, m_settle, m_adc;

   ppg_afe_emulator dut (
      .CLK(CLK), .rst(rst), .LED_RED(LED_RED), .LED_IR(LED_IR),
      .LED_DRIVE(LED_DRIVE), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
      .CLK_Filter(CLK_Filter), .ADC(ADC), .ADC_valid(ADC_valid)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_wave = 0; m_up = 1; m_prev = -1; m_settle = 0; m_adc = 128;
   endtask

   task automatic model_tick(input bit red, input bit ir, input int drive, input int comp,
                             input int gain, output bit v, output int adc);
      int ch, w, eff, raw, p;
      ch = (red && !ir) ? 1 : (ir && !red) ? 2 : 0;
      w = m_wave;
      if (m_up != 0) begin
         m_wave++;
         if (m_wave == 15) m_up = 0;
      end else begin
         m_wave--;
         if (m_wave == 0) m_up = 1;
      end
      eff = (m_prev != -1 && ch != m_prev) ? 2 : m_settle;
      m_prev = ch;
      if (eff != 0) begin
         m_settle = eff - 1;
         v = 1'b0;
         adc = m_adc;
      end else begin
         raw = (ch == 1) ? drive * 20 + w : (ch == 2) ? drive * 22 + w : 16;
         p = (raw - 2 * comp - 128) * (gain + 1) + 128;
         adc = (p < 0) ? 0 : (p > 255) ? 255 : p;
         m_adc = adc;
         v = 1'b1;
      end
   endtask

   task automatic scramble_inputs();
      LED_RED = 1'($urandom); LED_IR = 1'($urandom);
      LED_DRIVE = 4'($urandom); DC_Comp = 7'($urandom); PGA_Gain = 4'($urandom);
   endtask

   // One isolated tick: pulse CLK_Filter for one cycle, then watch the three-cycle latency
   task automatic one_tick(input string name, input bit red, input bit ir, input int drive,
                           input int comp, input int gain);
      bit v;
      int a;
      LED_RED = red; LED_IR = ir; LED_DRIVE = 4'(drive); DC_Comp = 7'(comp); PGA_Gain = 4'(gain);
      CLK_Filter = 1'b1;
      model_tick(red, ir, drive, comp, gain, v, a);
      step();
      CLK_Filter = 1'b0;
      scramble_inputs();
      checks++;
      if (ADC_valid !== 1'b0) begin
         errors++; $display("FAIL %s_early1 valid got %0b exp 0", name, ADC_valid);
      end
      step();
      checks++;
      if (ADC_valid !== 1'b0) begin
         errors++; $display("FAIL %s_early2 valid got %0b exp 0", name, ADC_valid);
      end
      step();
      checks++;
      if (ADC_valid !== v || ADC !== 8'(a)) begin
         errors++;
         $display("FAIL %s valid/adc got %0b/%0d exp %0b/%0d", name, ADC_valid, ADC, v, a);
      end
      step();
      checks++;
      if (ADC_valid !== 1'b0) begin
         errors++; $display("FAIL %s_late valid got %0b exp 0", name, ADC_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (ADC !== 8'h80 || ADC_valid !== 1'b0) begin
         errors++; $display("FAIL reset adc/valid got %0h/%0b exp 80/0", ADC, ADC_valid);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (ADC_valid !== 1'b0 || ADC !== 8'h80) begin
            errors++; $display("FAIL idle_no_tick adc/valid got %0h/%0b exp 80/0", ADC, ADC_valid);
         end
      end
   endtask

   task automatic test_wave();
      for (int i = 0; i < 31; i++)
         one_tick("wave", 1'b1, 1'b0, 10, 36, (i == 5) ? 3 : 0);
   endtask

   task automatic test_saturation();
      one_tick("sat_high", 1'b1, 1'b0, 10, 0, 15);
      one_tick("sat_low", 1'b1, 1'b0, 10, 127, 0);
   endtask

   task automatic test_channel_switch();
      for (int i = 0; i < 4; i++) one_tick("to_ir", 1'b0, 1'b1, 10, 36, int'($urandom_range(0, 3)));
      for (int i = 0; i < 3; i++) one_tick("to_red", 1'b1, 1'b0, 10, 36, 1);
      for (int i = 0; i < 3; i++) one_tick("to_dark", 1'b1, 1'b1, 10, 36, 2);
   endtask

   task automatic test_random();
      bit r, ir;
      r = 1'b1; ir = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = 1'($urandom); ir = 1'($urandom);
         end
         one_tick("random", r, ir, int'($urandom_range(0, 15)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 15)));
      end
   endtask

   task automatic test_back_to_back();
      bit exp_v[64];
      int exp_a[64];
      bit r, ir, v;
      int a, d, c, g;
      r = 1'b1; ir = 1'b0;
      for (int k = 0; k < 64; k++) begin
         exp_v[k] = 1'b0; exp_a[k] = 0;
      end
      for (int k = 0; k < 52; k++) begin
         checks++;
         if (k >= 3 && exp_v[k-3]) begin
            if (ADC_valid !== 1'b1 || ADC !== 8'(exp_a[k-3])) begin
               errors++;
               $display("FAIL b2b cycle %0d valid/adc got %0b/%0d exp 1/%0d", k, ADC_valid, ADC, exp_a[k-3]);
            end
         end else if (ADC_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle cycle %0d valid got %0b exp 0", k, ADC_valid);
         end
         if (k < 48 && k % 2 == 0) begin
            if ($urandom_range(0, 4) == 0) begin
               r = 1'($urandom); ir = 1'($urandom);
            end
            d = int'($urandom_range(0, 15)); c = int'($urandom_range(0, 127)); g = int'($urandom_range(0, 15));
            LED_RED = r; LED_IR = ir; LED_DRIVE = 4'(d); DC_Comp = 7'(c); PGA_Gain = 4'(g);
            CLK_Filter = 1'b1;
            model_tick(r, ir, d, c, g, v, a);
            exp_v[k] = v; exp_a[k] = a;
         end else begin
            CLK_Filter = 1'b0;
            scramble_inputs();
         end
         step();
      end
      CLK_Filter = 1'b0;
   endtask

   task automatic test_reset_mid();
      LED_RED = 1'b1; LED_IR = 1'b0; LED_DRIVE = 4'd10; DC_Comp = 7'd0; PGA_Gain = 4'd15;
      CLK_Filter = 1'b1;
      step();
      CLK_Filter = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_reset();
      checks++;
      if (ADC !== 8'h80) begin
         errors++; $display("FAIL reset_mid adc got %0h exp 80", ADC);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ADC_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flush valid got %0b exp 0", ADC_valid);
         end
      end
      one_tick("after_reset", 1'b1, 1'b0, 10, 36, 0);
      one_tick("after_reset2", 1'b0, 1'b1, 10, 36, 0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_wave();
      test_saturation();
      test_channel_switch();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
